// File: rtl/mem_stage_unit_if.sv
// Data-RAM request/ack bus and stdout byte stream seen from the MEM stage.
// master = MEM stage side, slave = RAM controller / UART TX side.
interface mem_stage_unit_if #(
  parameter int RAM_ADDR_WIDTH = 16
);
  logic                      ram_req;
  logic                      ram_we;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]               ram_wdata;
  logic [31:0]               ram_rdata;
  logic                      ram_ack;
  logic                      tx_valid;
  logic [7:0]                tx_data;
  logic                      tx_ready;

  modport master (
    output ram_req, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ack,
    output tx_valid, tx_data,
    input  tx_ready
  );

  modport slave (
    input  ram_req, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ack,
    input  tx_valid, tx_data,
    output tx_ready
  );
endinterface

// File: rtl/mem_stage_unit.sv
// MEM stage: RAM load/store over req/ack, stdout byte FIFO, next-PC and write-back select.
// Load data is forwarded on the ack cycle; mem_stall holds upstream while RAM is pending or stdout FIFO is full.
module mem_stage_unit #(
  parameter int RAM_ADDR_WIDTH    = 16,
  parameter int STDOUT_FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_data,
  input  logic [31:0]          rs2_data,
  input  logic [4:0]           rd_address,
  input  logic [31:0]          alu_rd_result,
  input  logic                 alu_rd_result_is_zero,
  input  logic [31:0]          alu_pc_result,
  input  logic [1:0]           next_pc_src,
  input  logic [1:0]           reg_write_data_src,
  input  logic                 reg_write_enable,
  input  logic                 ram_write_enable,
  input  logic                 stdout_write_enable,
  mem_stage_unit_if.master     bus,
  output logic                 mem_stall,
  output logic                 pc_redirect,
  output logic [31:0]          next_pc,
  output logic [4:0]           wb_rd_address,
  output logic [31:0]          wb_reg_write_data,
  output logic                 wb_reg_write_enable
);

  localparam int PTR_W = $clog2(STDOUT_FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(STDOUT_FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state, state_nxt;

  logic                      need_ram;
  logic                      ram_req;
  logic                      ram_stall;
  logic                      fifo_stall;
  logic                      fifo_full;
  logic                      push;
  logic                      pop;
  logic                      taken;
  logic                      hold_we;
  logic [RAM_ADDR_WIDTH-1:0] hold_addr;
  logic [31:0]               hold_wdata;

  logic [7:0]                fifo_mem [STDOUT_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [PTR_W:0]            count;

  assign need_ram = ram_write_enable | (reg_write_enable & (reg_write_data_src == 2'd1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ram_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        ram_req = need_ram;
        if (need_ram && !bus.ram_ack) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        ram_req = 1'b1;
        if (bus.ram_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request fields are frozen at issue so they cannot move while ram_req is held.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      hold_we    <= ram_write_enable;
      hold_addr  <= alu_rd_result[RAM_ADDR_WIDTH+1:2];
      hold_wdata <= rs2_data;
    end
  end

  assign bus.ram_req   = ram_req;
  assign bus.ram_we    = (state == ST_WAIT) ? hold_we    : ram_write_enable;
  assign bus.ram_addr  = (state == ST_WAIT) ? hold_addr  : alu_rd_result[RAM_ADDR_WIDTH+1:2];
  assign bus.ram_wdata = (state == ST_WAIT) ? hold_wdata : rs2_data;

  assign ram_stall  = need_ram & ~(ram_req & bus.ram_ack);
  assign fifo_full  = (count == FULL_COUNT);
  // No pop->push bypass: a full FIFO stalls even if a byte drains this cycle.
  assign fifo_stall = stdout_write_enable & fifo_full;
  assign push       = stdout_write_enable & ~fifo_full & ~ram_stall;
  assign pop        = (count != '0) & bus.tx_ready;
  assign mem_stall  = ram_stall | fifo_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rs2_data[7:0];
  end

  assign bus.tx_valid = (count != '0);
  assign bus.tx_data  = fifo_mem[rd_ptr];

  always_comb begin
    taken = 1'b0;
    case (next_pc_src)
      2'd1:    taken = 1'b1;
      2'd2:    taken = alu_rd_result_is_zero;
      2'd3:    taken = ~alu_rd_result_is_zero;
      default: taken = 1'b0;
    endcase
  end

  assign pc_redirect = taken & ~mem_stall;
  assign next_pc     = alu_pc_result;

  always_comb begin
    wb_reg_write_data = 32'd0;
    case (reg_write_data_src)
      2'd0:    wb_reg_write_data = alu_rd_result;
      2'd1:    wb_reg_write_data = bus.ram_rdata;
      2'd2:    wb_reg_write_data = pc_data + 32'd4;
      default: wb_reg_write_data = 32'd0;
    endcase
  end

  assign wb_rd_address       = rd_address;
  assign wb_reg_write_enable = reg_write_enable & ~mem_stall;

endmodule
